// File: rtl/conditional_sub_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conditional_sub_pipe_if : stream handshake bundle for conditional_sub_pipe |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface conditional_sub_pipe_if #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 12
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/conditional_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conditional_sub_pipe : two-stage mod-Q trim of [0,2Q) values, with error   |
// | flagging and a saturating error counter.  Rev 1.0                          |
// +----------------------------------------------------------------------------+
module conditional_sub_pipe #(
  parameter int Q     = 3329,
  parameter int IN_W  = 13,
  parameter int OUT_W = 12,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  conditional_sub_pipe_if.slave  bus,
  input  logic                   clear_err,
  output logic                   err_sticky,
  output logic [CNT_W-1:0]       err_count
);

  localparam logic [IN_W:0]    c_q_ext   = (IN_W+1)'(Q);
  localparam logic [IN_W:0]    c_2q_ext  = (IN_W+1)'(2 * Q);
  localparam logic [OUT_W-1:0] c_q_lo    = OUT_W'(Q);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0] s1_x_q, s1_x_d;
  logic [OUT_W-1:0] s1_diff_q, s1_diff_d;
  logic             s1_ge_q, s1_ge_d;
  logic             s1_oor_q, s1_oor_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic w_s2_take;
  logic w_s1_move;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;
  logic w_in_ge;
  logic w_in_oor;

  assign w_s2_take  = ~s2_valid_q | bus.out_ready;
  assign w_s1_move  = s1_valid_q & w_s2_take;
  assign w_in_ready = ~s1_valid_q | w_s1_move;
  assign w_in_fire  = bus.in_valid & w_in_ready;
  assign w_out_fire = s2_valid_q & bus.out_ready;

  assign w_in_ge  = {1'b0, bus.in_data} >= c_q_ext;
  assign w_in_oor = {1'b0, bus.in_data} >= c_2q_ext;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_x_d       = s1_x_q;
    s1_diff_d    = s1_diff_q;
    s1_ge_d      = s1_ge_q;
    s1_oor_d     = s1_oor_q;
    s2_valid_d   = s2_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;

    // Only the low OUT_W bits of x - Q are ever presented, so the
    // subtraction is done at output width; wrap-around is intended.
    if (w_in_fire) begin
      s1_valid_d = 1'b1;
      s1_x_d     = bus.in_data[OUT_W-1:0];
      s1_diff_d  = bus.in_data[OUT_W-1:0] - c_q_lo;
      s1_ge_d    = w_in_ge;
      s1_oor_d   = w_in_oor;
    end else if (w_s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (w_s1_move) begin
      s2_valid_d = 1'b1;
      out_data_d = s1_ge_q ? s1_diff_q : s1_x_q;
      out_err_d  = s1_oor_q;
    end else if (w_out_fire) begin
      s2_valid_d = 1'b0;
    end

    // Errors are booked at acceptance; a simultaneous clear takes priority.
    if (clear_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end else if (w_in_fire && w_in_oor) begin
      err_sticky_d = 1'b1;
      if (err_count_q != c_cnt_max) begin
        err_count_d = err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_diff_q    <= '0;
      s1_ge_q      <= 1'b0;
      s1_oor_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_diff_q    <= s1_diff_d;
      s1_ge_q      <= s1_ge_d;
      s1_oor_q     <= s1_oor_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = s2_valid_q;
  assign err_sticky    = err_sticky_q;
  assign err_count     = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_conditional_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conditional_sub_pipe : directed vector bench for conditional_sub_pipe   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conditional_sub_pipe;

  logic       clk;
  logic       rst;
  logic       clear_err;
  logic       err_sticky;
  logic [7:0] err_count;

  int n_cmp;
  int n_fail;

  conditional_sub_pipe_if #(.IN_W(13), .OUT_W(12)) bus ();

  conditional_sub_pipe #(
    .Q     (3329),
    .IN_W  (13),
    .OUT_W (12),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear_err  (clear_err),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] x;
    logic [11:0] exp_data;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_one(input vec_t v);
    @(posedge clk); #1;
    bus.in_data   = v.x;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check("single_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("single_not_early", bus.out_valid, 0);
    @(posedge clk); #1;
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_data", bus.out_data, v.exp_data);
    check("single_out_err", bus.out_err, v.exp_err);
    check("single_err_count", err_count, v.exp_cnt);
    check("single_err_sticky", err_sticky, v.exp_cnt != 0);
  endtask

  logic [12:0] items [64];
  logic [11:0] sb [$];

  initial begin
    int sent;
    int recv;
    int cycles;
    logic [11:0] exp;

    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{13'd0,    12'd0,    1'b0, 8'd0};
    vecs[1] = '{13'd3328, 12'd3328, 1'b0, 8'd0};
    vecs[2] = '{13'd3329, 12'd0,    1'b0, 8'd0};
    vecs[3] = '{13'd6657, 12'd3328, 1'b0, 8'd0};
    vecs[4] = '{13'd6658, 12'd3329, 1'b1, 8'd1};
    vecs[5] = '{13'd8191, 12'd766,  1'b1, 8'd2};

    rst           = 1'b1;
    clear_err     = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_one(vecs[i]);
    end

    // Backpressure: two items fill the pipe, the third is refused.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 13'd100;
    check("bp_ready_0", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_data = 13'd200;
    check("bp_ready_1", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_data = 13'd3400;
    check("bp_ready_full", bus.in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_data", bus.out_data, 100);
      check("bp_hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_seq_1_valid", bus.out_valid, 1);
    check("bp_seq_1", bus.out_data, 200);
    @(posedge clk); #1;
    check("bp_seq_2_valid", bus.out_valid, 1);
    check("bp_seq_2", bus.out_data, 71);
    @(posedge clk); #1;
    check("bp_drained", bus.out_valid, 0);

    // Streaming with random output stalls against a FIFO scoreboard.
    for (int i = 0; i < 64; i++) items[i] = 13'($urandom_range(0, 6657));
    sent   = 0;
    recv   = 0;
    cycles = 0;
    while (recv < 64 && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
      bus.in_valid  = (sent < 64);
      bus.in_data   = (sent < 64) ? items[sent] : 13'd0;
      bus.out_ready = 1'($urandom_range(0, 1));
      #3;
      if (bus.out_valid && bus.out_ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 12'hfff;
        check("stream_data", bus.out_data, exp);
        check("stream_err", bus.out_err, 0);
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(12'(items[sent] % 13'd3329));
        sent++;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_count_in", sent, 64);
    check("stream_count_out", recv, sent);
    check("stream_err_count", err_count, 2);

    // Saturation of the error counter.
    @(posedge clk); #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    check("clr_count", err_count, 0);
    check("clr_sticky", err_sticky, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 13'd8000;
    @(posedge clk); #1;
    check("sat_first_count", err_count, 1);
    check("sat_first_sticky", err_sticky, 1);
    repeat (299) @(posedge clk);
    #1;
    check("sat_count", err_count, 255);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err    = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_vs_oor_count", err_count, 0);
    check("clr_vs_oor_sticky", err_sticky, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset with two items in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 13'd10;
    @(posedge clk); #1;
    bus.in_data = 13'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rst_mid_full", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid_drop", bus.out_valid, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 13'd5000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("rst_mid_no_stale", bus.out_valid, 0);
    @(posedge clk); #1;
    check("rst_mid_new_valid", bus.out_valid, 1);
    check("rst_mid_new_data", bus.out_data, 1671);
    check("rst_mid_new_err", bus.out_err, 0);
    @(posedge clk); #1;
    check("rst_mid_single", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conditional_sub_pipe.md
Name: conditional_sub_pipe

Overview:
- Streaming modular reducer for Kyber (q = 3329). Maps a butterfly sum in [0, 2q) to [0, q) by subtracting q when the input is >= q.
- Inverse-direction partner of the conditional-add stage, which lifts negative differences into range. This block trims positive overflow.
- Sits between butterfly adder outputs and the coefficient memory write port.
- Two-stage pipeline with valid/ready flow control on both sides, plus out-of-range error reporting.

Parameters:
- Q, 3329, modulus. Must satisfy 2*Q <= 2^IN_W.
- IN_W, 13, input width. Input is unsigned.
- OUT_W, 12, output width. Must satisfy 2^OUT_W > Q.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  IN_W  unsigned value, nominally in [0, 2Q).
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  OUT_W  reduced value.
- out_err  out  1  sideband: the input for this item was >= 2Q.
- out_valid  out  1  out_data and out_err are valid.
- out_ready  in  1  downstream accepts this cycle.
- clear_err  in  1  synchronous clear of err_sticky and err_count.
- err_sticky  out  1  set when any out-of-range item has been accepted.
- err_count  out  CNT_W  number of out-of-range items accepted, saturating.

Behaviour:
- Reset (async assert, state takes effect immediately): s1_valid, s2_valid, out_valid, out_err, err_sticky and err_count are all 0; out_data is 0.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Stage 1 (register), loaded on input transfer:
  - x = in_data.
  - d = x - Q, computed IN_W+1 bits wide.
  - ge = ~d[IN_W], i.e. x >= Q.
  - oor = (x >= 2Q).
- Stage 2 (register, drives the outputs):
  - out_data = ge ? d[OUT_W-1:0] : x[OUT_W-1:0].
  - out_err = oor.
- Flow control (no bubbles, no combinational path out_ready -> out_valid):
  - s2_take = ~s2_valid | out_ready.
  - s1_move = s1_valid & s2_take.
  - in_ready = ~s1_valid | s1_move. This is combinational from out_ready and is permitted.
- Stage 1 update per cycle:
  - On input transfer, stage 1 loads the new item.
  - Else if s1_move, s1_valid clears.
  - Simultaneous move-out and load is allowed and keeps the pipe full.
- Stage 2 update per cycle:
  - If s1_move, stage 2 loads from stage 1.
  - Else if output transfer, s2_valid clears.
  - Otherwise stage 2 holds.
  - out_data and out_err must stay stable while out_valid & ~out_ready.
- Latency: an item accepted in cycle N is presented with out_valid in cycle N+2 if unstalled.
- Throughput: 1 item/cycle. Capacity: 2 items.
- Ordering: strict FIFO order. No item is dropped or duplicated.
- Out-of-range input (x >= 2Q):
  - out_data is the low OUT_W bits of x - Q, with out_err = 1.
  - Error state is updated on the cycle the item is accepted (input transfer), not on output.
- Error counter:
  - err_count increments by 1 per accepted out-of-range item and saturates at 2^CNT_W - 1.
  - err_sticky sets on the same cycle.
- clear_err:
  - Zeroes err_count and err_sticky next cycle.
  - If an out-of-range accept occurs in the same cycle, clear wins for the counter and sticky.
  - Pipeline contents are unaffected.
- Boundary values:
  - x = Q-1 passes unchanged.
  - x = Q gives 0.
  - x = 2Q-1 gives Q-1.
- Reset mid-stream: all in-flight items are discarded and in_ready = 1 after release.

Test Plan:
- Single items with out_ready = 1; inputs 0, 3328, 3329, 6657 → out_data 0, 3328, 0, 3328; out_err = 0; each appears 2 cycles after accept.
- Input 6658 → out_data 3329, out_err 1, err_count 1, err_sticky 1. Input 8191 → out_data 766, out_err 1, err_count 2.
- Backpressure: out_ready = 0, offer 100, 200, 3400 back-to-back → first two accepted, in_ready = 0 on the third. Hold 5 cycles: out_data stays 100. Raise out_ready → outputs 100, 200, 71 in order with no gaps.
- Streaming: 64 random items in [0, 6658) with random out_ready at 50% duty → scoreboard matches x mod 3329 in order; count in equals count out.
- Error saturation: 300 inputs of 8000 → err_count holds at 255. Pulse clear_err in the same cycle as an out-of-range accept → err_count 0, err_sticky 0.
- Assert rst with 2 items in flight → out_valid drops immediately; after release, a new input 5000 → out_data 1671 with no stale output.
